// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first, behind valid/ready handshakes.
// Define SERIAL_SUB_OVERFLOW_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic [1:0]       fs;
  logic             accept;
  logic             last_bit;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic br);
    return {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
  endfunction

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (state == SHIFT) && (cnt_q == LAST_BIT);
  assign fs       = fs_bit(a_q[cnt_q], b_q[cnt_q], br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only consumed while shifting, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      br_q  <= 1'b0;
      d_q   <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      br_q  <= bin;
      d_q   <= '0;
    end else if (state == SHIFT) begin
      d_q[cnt_q] <= fs[0];
      br_q       <= fs[1];
      cnt_q      <= cnt_q + 1'b1;
    end
  end

  assign D    = d_q;
  assign bout = br_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Borrow entering the MSB cell, kept so ovf can be formed against the final borrow.
  logic msb_br_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        msb_br_q <= 1'b0;
    else if (accept)   msb_br_q <= 1'b0;
    else if (last_bit) msb_br_q <= br_q;
  end

  assign ovf = msb_br_q ^ br_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=8 cases plus exhaustive WIDTH=2 against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a8 = '0, b8 = '0, d8;
  logic       bin8 = 1'b0, iv8 = 1'b0, or8 = 1'b0, ir8, bo8, ov8, busy8;
  logic [1:0] a2 = '0, b2 = '0, d2;
  logic       bin2 = 1'b0, iv2 = 1'b0, or2 = 1'b0, ir2, bo2, ov2, busy2;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf8, ovf2;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .bin(bin8), .in_valid(iv8),
    .in_ready(ir8), .D(d8), .bout(bo8), .out_valid(ov8), .out_ready(or8), .busy(busy8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .bin(bin2), .in_valid(iv2),
    .in_ready(ir2), .D(d2), .bout(bo2), .out_valid(ov2), .out_ready(or2), .busy(busy2)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf2)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [7:0] ref_d8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return 8'(r);
  endfunction

  function automatic logic ref_bout(input int a, input int b, input logic bi);
    return a < (b + int'(bi));
  endfunction

  function automatic logic ref_ovf8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int s;
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return (s < -128) || (s > 127);
  endfunction

  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input string tag, input logic rel);
    logic early;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    a8 = a; b8 = b; bin8 = bi; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    chk({tag, "_accept_busy"}, busy8, 1);
    chk({tag, "_accept_ir"}, ir8, 0);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    early = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (ov8) early = 1'b1;
    end
    chk({tag, "_no_early_valid"}, early, 0);
    @(negedge clk);
    chk({tag, "_valid"}, ov8, 1);
    chk({tag, "_D"}, d8, ref_d8(a, b, bi));
    chk({tag, "_bout"}, bo8, ref_bout(int'(a), int'(b), bi));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, ovf8, ref_ovf8(a, b, bi));
`endif
    @(negedge clk);
    chk({tag, "_released"}, ov8, 0);
    chk({tag, "_idle_ir"}, ir8, 1);
  endtask

  logic [2:0] exq[$];
  logic [2:0] e;
  logic       seen;
  int         n, idx, got, cyc;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ir8", ir8, 1);
    chk("rst_ov8", ov8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_d8", d8, 0);
    chk("rst_bo8", bo8, 0);
    chk("rst_ir2", ir2, 1);
    chk("rst_ov2", ov2, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf8", ovf8, 0);
`endif

    // Directed WIDTH=8 cases; the first accepts on the first edge after release
    txn8(8'h50, 8'h20, 1'b0, "basic", 1'b1);
    txn8(8'h00, 8'h00, 1'b1, "zero_bin", 1'b0);
    txn8(8'h10, 8'h20, 1'b0, "neg", 1'b0);
    txn8(8'h5A, 8'h5A, 1'b0, "equal", 1'b0);
    txn8(8'h80, 8'h01, 1'b0, "ovf_a", 1'b0);
    txn8(8'h7F, 8'h01, 1'b0, "ovf_b", 1'b0);
    txn8(8'hFF, 8'hFF, 1'b1, "ff_bin", 1'b0);
    repeat (5) txn8(8'($urandom), 8'($urandom), 1'($urandom), "rand", 1'b0);

    // Backpressure: result held for 5 cycles while a new in_valid is ignored
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b1; iv8 = 1'b1; or8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", ov8, 1);
    iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(negedge clk);
      chk("bp_hold_valid", ov8, 1);
      chk("bp_hold_D", d8, ref_d8(8'hC3, 8'h3C, 1'b1));
      chk("bp_hold_bout", bo8, ref_bout(8'hC3, 8'h3C, 1'b1));
      chk("bp_hold_ir", ir8, 0);
    end
    a8 = 8'h33; b8 = 8'h44; bin8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", ov8, 0);
    chk("bp_hs_no_accept", busy8, 0);
    chk("bp_hs_ir", ir8, 1);
    @(negedge clk);
    chk("bp_next_accept", busy8, 1);
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_valid", ov8, 1);
    chk("bp_next_D", d8, ref_d8(8'h33, 8'h44, 1'b0));
    chk("bp_next_bout", bo8, ref_bout(8'h33, 8'h44, 1'b0));
    @(negedge clk);
    chk("bp_next_idle", busy8, 0);

    // Reset in SHIFT cycle 4 with partial D and a pending borrow
    a8 = 8'h00; b8 = 8'h07; bin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy8, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", ir8, 1);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_valid", ov8, 0);
    chk("mid_rst_D", d8, 0);
    chk("mid_rst_bout", bo8, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("mid_rst_ovf", ovf8, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ov8 || busy8) seen = 1'b1;
    end
    chk("mid_no_result", seen, 0);

    // Exhaustive WIDTH=2: all 32 operand combinations, back-to-back, random out_ready
    idx = 0; got = 0; cyc = 0;
    while (got < 32 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      or2 = 1'($urandom);
      if (idx < 32) begin
        {a2, b2, bin2} = 5'(idx);
        iv2 = 1'b1;
      end else begin
        iv2 = 1'b0;
      end
      if (iv2 && ir2) begin
        e[1:0] = 2'(int'(a2) - int'(b2) - int'(bin2));
        e[2]   = ref_bout(int'(a2), int'(b2), bin2);
        exq.push_back(e);
        idx++;
      end
      if (ov2 && or2) begin
        if (exq.size() == 0) begin
          chk("w2_unexpected_valid", ov2, 0);
        end else begin
          e = exq.pop_front();
          chk("w2_D", d2, e[1:0]);
          chk("w2_bout", bo2, e[2]);
          got++;
        end
      end
    end
    chk("w2_result_count", got, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
